// File: rtl/da_dct_seq_ctrl.sv
// -----------------------------------------------------------------------------
// da_dct_seq_ctrl
//   Sequencer for one distributed-arithmetic DCT coefficient lane. It accepts
//   a set of four signed samples, walks their bit planes MSB-first, forms the
//   3-bit coefficient-ROM address for each plane and shift-accumulates the
//   signed ROM words into a single DCT output.
//
//   The ROM stores only the x0=0 half of the offset-binary table. When x0's bit
//   is set, the controller looks up the complemented address and negates the
//   word. The MSB plane carries negative weight (two's complement), so its
//   sign is flipped as well.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   sample set valid
//   in_ready   out  controller idle and able to take a set
//   in_x       in   {x3,x2,x1,x0}, x0 in the LSBs, each DATA_W bits signed
//   rom_cs     out  ROM chip select, high only while walking planes
//   rom_addr   out  ROM address for the current plane
//   rom_data   in   ROM word, combinational from rom_addr
//   rom_rst_n  out  ROM reset, inverse of rst
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   downstream accepts the result
//   out_z      out  signed DA result, held until the next result
//
// Build option
//   DA_ROUND_EN : when defined, out_z is the accumulator rounded half-up and
//                 arithmetically shifted right by ROUND_SH; otherwise out_z is
//                 the full-precision accumulator.
// -----------------------------------------------------------------------------
module da_dct_seq_ctrl #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 16,
  parameter int ACC_W    = 25,
  parameter int ROUND_SH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DATA_W-1:0] in_x,
  output logic                rom_cs,
  output logic [2:0]          rom_addr,
  input  logic [COEF_W-1:0]   rom_data,
  output logic                rom_rst_n,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_z
);

  localparam int PLANE_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [PLANE_W-1:0] PLANE_TOP = PLANE_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_WARM = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // ROM address for bit plane b: {x1,x2,x3} bits, complemented when x0's bit
  // is set (the ROM holds only the x0=0 half of the symmetric table).
  function automatic logic [2:0] plane_addr(input logic [4*DATA_W-1:0] x,
                                            input logic [PLANE_W-1:0]  b);
    logic [DATA_W-1:0] x0;
    logic [DATA_W-1:0] x1;
    logic [DATA_W-1:0] x2;
    logic [DATA_W-1:0] x3;
    logic [2:0]        v;
    x0 = x[0*DATA_W +: DATA_W];
    x1 = x[1*DATA_W +: DATA_W];
    x2 = x[2*DATA_W +: DATA_W];
    x3 = x[3*DATA_W +: DATA_W];
    v  = {x1[b], x2[b], x3[b]};
    return x0[b] ? ~v : v;
  endfunction

  // Output shaping of the final accumulator value.
  function automatic logic [ACC_W-1:0] shape_result(input logic [ACC_W-1:0] acc);
`ifdef DA_ROUND_EN
    logic signed [ACC_W-1:0] biased;
    biased = $signed(acc + (ACC_W'(1) << (ROUND_SH - 1)));
    return ACC_W'(biased >>> ROUND_SH);
`else
    return acc;
`endif
  endfunction

  state_t                state_q, state_d;
  logic [PLANE_W-1:0]    plane_q, plane_d;
  logic [4*DATA_W-1:0]   x_q, x_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  in_ready_q, in_ready_d;
  logic                  rom_cs_q, rom_cs_d;
  logic [2:0]            rom_addr_q, rom_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic [ACC_W-1:0]      out_z_q, out_z_d;

  logic [DATA_W-1:0]     x0_s;
  logic                  neg_s;
  logic [ACC_W-1:0]      rom_ext_s;
  logic [ACC_W-1:0]      term_s;
  logic [ACC_W-1:0]      acc_step_s;

  // Per-plane shift-accumulate term from the ROM word of the current plane.
  always_comb begin
    x0_s       = x_q[DATA_W-1:0];
    // x0's bit selects the mirrored half; the MSB plane has negative weight.
    neg_s      = x0_s[plane_q] ^ (plane_q == PLANE_TOP);
    rom_ext_s  = {{(ACC_W-COEF_W){rom_data[COEF_W-1]}}, rom_data};
    term_s     = neg_s ? (~rom_ext_s + ACC_W'(1)) : rom_ext_s;
    acc_step_s = {acc_q[ACC_W-2:0], 1'b0} + term_s;
  end

  // Next-state logic and next values of all registered outputs.
  always_comb begin
    state_d     = state_q;
    plane_d     = plane_q;
    x_d         = x_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    rom_cs_d    = rom_cs_q;
    rom_addr_d  = rom_addr_q;
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;
    case (state_q)
      ST_WARM: begin
        // One cycle for the ROM's reset synchroniser to release.
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
      end
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = ST_RUN;
          x_d        = in_x;
          plane_d    = PLANE_TOP;
          acc_d      = {ACC_W{1'b0}};
          in_ready_d = 1'b0;
          rom_cs_d   = 1'b1;
          // Address is registered one plane ahead so it lines up with rom_data.
          rom_addr_d = plane_addr(in_x, PLANE_TOP);
        end else begin
          in_ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        acc_d = acc_step_s;
        if (plane_q == {PLANE_W{1'b0}}) begin
          state_d     = ST_DONE;
          rom_cs_d    = 1'b0;
          rom_addr_d  = 3'd0;
          out_valid_d = 1'b1;
          out_z_d     = shape_result(acc_step_s);
        end else begin
          plane_d    = plane_q - PLANE_W'(1);
          rom_addr_d = plane_addr(x_q, plane_q - PLANE_W'(1));
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_WARM;
        in_ready_d  = 1'b0;
        rom_cs_d    = 1'b0;
        rom_addr_d  = 3'd0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WARM;
      plane_q     <= {PLANE_W{1'b0}};
      x_q         <= {(4*DATA_W){1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      in_ready_q  <= 1'b0;
      rom_cs_q    <= 1'b0;
      rom_addr_q  <= 3'd0;
      out_valid_q <= 1'b0;
      out_z_q     <= {ACC_W{1'b0}};
    end else begin
      state_q     <= state_d;
      plane_q     <= plane_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      rom_cs_q    <= rom_cs_d;
      rom_addr_q  <= rom_addr_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign rom_cs    = rom_cs_q;
  assign rom_addr  = rom_addr_q;
  assign rom_rst_n = ~rst;
  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;

endmodule
